// File: rtl/mountaincar_step_ctrl_pkg.sv
// Shared types and constants for the mountain-car step controller.
// Float constants are IEEE-754 single precision bit patterns.
package mountaincar_step_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VEL,
    POS,
    FIX,
    PUB
  } state_t;

  localparam int FP_WL = 32;

  localparam logic [FP_WL-1:0] VEL_MAX  = 32'h3D8F5C29;
  localparam logic [FP_WL-1:0] POS_MIN  = 32'hBF99999A;
  localparam logic [FP_WL-1:0] POS_MAX  = 32'h3F19999A;
  localparam logic [FP_WL-1:0] GOAL_POS = 32'h3F000000;
  localparam logic [FP_WL-1:0] FP_ZERO  = 32'h00000000;

  localparam logic [1:0] ACT_LEFT  = 2'd0;
  localparam logic [1:0] ACT_NONE  = 2'd1;
  localparam logic [1:0] ACT_RIGHT = 2'd2;
  localparam logic [1:0] ACT_BAD   = 2'd3;

  // Sign-magnitude a < b; both zeros compare equal.
  function automatic logic fp_lt(
    input logic [FP_WL-1:0] a,
    input logic [FP_WL-1:0] b
  );
    logic a_z;
    logic b_z;
    a_z = (a[FP_WL-2:0] == '0);
    b_z = (b[FP_WL-2:0] == '0);
    if (a_z && b_z)
      return 1'b0;
    if (a[FP_WL-1] != b[FP_WL-1])
      return a[FP_WL-1];
    if (!a[FP_WL-1])
      return a[FP_WL-2:0] < b[FP_WL-2:0];
    return a[FP_WL-2:0] > b[FP_WL-2:0];
  endfunction

endpackage

// File: rtl/mountaincar_step_ctrl_fp_clamp.sv
// Float clamp to [lo, hi] with saturation flags.
// Pure combinational; used for both velocity and position.
module mountaincar_fp_clamp
  import mountaincar_step_ctrl_pkg::*;
(
  input  logic [FP_WL-1:0] i_val,
  input  logic [FP_WL-1:0] i_lo,
  input  logic [FP_WL-1:0] i_hi,
  output logic [FP_WL-1:0] o_val,
  output logic             o_at_lo,
  output logic             o_at_hi
);

  logic w_at_lo;
  logic w_at_hi;

  assign w_at_lo = !fp_lt(i_lo, i_val);
  assign w_at_hi = !fp_lt(i_val, i_hi);

  always_comb begin
    o_val = i_val;
    unique case (1'b1)
      w_at_lo: o_val = i_lo;
      w_at_hi: o_val = i_hi;
      default: o_val = i_val;
    endcase
  end

  assign o_at_lo = w_at_lo;
  assign o_at_hi = w_at_hi;

endmodule

// File: rtl/mountaincar_step_ctrl.sv
// Mountain-car environment step sequencer around external
// velocity and position arithmetic units.
module mountaincar_step_ctrl
  import mountaincar_step_ctrl_pkg::*;
#(
  parameter int VEL_WL    = 32,
  parameter int POS_WL    = 32,
  parameter int ACT_WL    = 2,
  parameter int MAX_STEPS = 200,
  parameter int CNT_WL    = 8,
  parameter int TMO_CYC   = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ep_reset,
  input  logic [POS_WL-1:0] i_init_pos,
  input  logic              i_act_valid,
  output logic              o_act_ready,
  input  logic [ACT_WL-1:0] i_act,
  output logic              o_vel_ena,
  output logic [VEL_WL-1:0] o_vel_vel,
  output logic [POS_WL-1:0] o_vel_pos,
  output logic [ACT_WL-1:0] o_vel_act,
  input  logic              i_vel_valid,
  input  logic [VEL_WL-1:0] i_vel,
  output logic              o_pos_ena,
  output logic [POS_WL-1:0] o_pos_pos,
  output logic [VEL_WL-1:0] o_pos_vel,
  input  logic              i_pos_valid,
  input  logic [POS_WL-1:0] i_pos,
  output logic              o_state_valid,
  output logic [POS_WL-1:0] o_pos,
  output logic [VEL_WL-1:0] o_vel,
  output logic              o_done,
  output logic              o_trunc,
  output logic              o_err,
  output logic [CNT_WL-1:0] o_step_cnt
);

  localparam int TMO_WL = $clog2(TMO_CYC + 1);
  localparam logic [TMO_WL-1:0] TMO_LAST = TMO_WL'(TMO_CYC - 1);
  localparam logic [CNT_WL-1:0] CNT_MAX  = CNT_WL'(MAX_STEPS);

  state_t r_state;
  state_t w_nxt;

  logic              r_loaded;
  logic              r_pend;
  logic [POS_WL-1:0] r_init;
  logic [ACT_WL-1:0] r_act;
  logic [POS_WL-1:0] r_pos;
  logic [VEL_WL-1:0] r_vel;
  logic [POS_WL-1:0] r_pos_new;
  logic [VEL_WL-1:0] r_vel_new;
  logic [CNT_WL-1:0] r_cnt;
  logic [TMO_WL-1:0] r_tmo;
  logic              r_done;
  logic              r_trunc;
  logic              r_err;
  logic              r_state_valid;
  logic              r_vel_ena;
  logic              r_pos_ena;

  logic              w_ready;
  logic              w_hs;
  logic              w_bad;
  logic              w_abort;
  logic              w_tmo_hit;
  logic              w_load;
  logic [POS_WL-1:0] w_ld_pos;
  logic [VEL_WL-1:0] w_vel_lo;
  logic [VEL_WL-1:0] w_vel_clamp;
  logic [POS_WL-1:0] w_pos_clamp;
  logic              w_vel_at_lo;
  logic              w_vel_at_hi;
  logic              w_pos_at_lo;
  logic              w_pos_at_hi;
  logic              w_goal;
  logic              w_vel_neg;
  logic [CNT_WL-1:0] w_cnt_nx;
  logic              w_unused;

  assign w_vel_lo = {1'b1, VEL_MAX[VEL_WL-2:0]};

  mountaincar_fp_clamp u_vel_clamp (
    .i_val   (i_vel),
    .i_lo    (w_vel_lo),
    .i_hi    (VEL_MAX),
    .o_val   (w_vel_clamp),
    .o_at_lo (w_vel_at_lo),
    .o_at_hi (w_vel_at_hi)
  );

  mountaincar_fp_clamp u_pos_clamp (
    .i_val   (r_pos_new),
    .i_lo    (POS_MIN),
    .i_hi    (POS_MAX),
    .o_val   (w_pos_clamp),
    .o_at_lo (w_pos_at_lo),
    .o_at_hi (w_pos_at_hi)
  );

  assign w_unused = ^{w_vel_at_lo, w_vel_at_hi, w_pos_at_hi};

  assign w_ready = (r_state == IDLE) && r_loaded && !r_pend
                && !r_done && !r_trunc;
  assign w_hs    = w_ready && i_act_valid && !i_ep_reset;
  assign w_bad   = (i_act == ACT_WL'(ACT_BAD));
  assign w_abort = i_ep_reset && (r_state != IDLE);
  assign w_load  = (r_state == IDLE) && (i_ep_reset || r_pend);
  assign w_ld_pos = i_ep_reset ? i_init_pos : r_init;

  assign w_tmo_hit = !i_ep_reset && (r_tmo == TMO_LAST)
                  && (((r_state == VEL) && !i_vel_valid)
                   || ((r_state == POS) && !i_pos_valid));

  assign w_vel_neg = fp_lt(r_vel_new, FP_ZERO);
  assign w_goal    = !fp_lt(r_pos_new, GOAL_POS)
                  && !fp_lt(r_vel_new, FP_ZERO);
  assign w_cnt_nx  = r_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_hs && !w_bad) w_nxt = VEL;
      VEL: begin
        if (w_abort || w_tmo_hit) w_nxt = IDLE;
        else if (i_vel_valid)     w_nxt = POS;
      end
      POS: begin
        if (w_abort || w_tmo_hit) w_nxt = IDLE;
        else if (i_pos_valid)     w_nxt = FIX;
      end
      FIX:     w_nxt = w_abort ? IDLE : PUB;
      PUB:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loaded      <= 1'b0;
      r_pend        <= 1'b0;
      r_init        <= '0;
      r_act         <= '0;
      r_pos         <= '0;
      r_vel         <= '0;
      r_pos_new     <= '0;
      r_vel_new     <= '0;
      r_cnt         <= '0;
      r_tmo         <= '0;
      r_done        <= 1'b0;
      r_trunc       <= 1'b0;
      r_err         <= 1'b0;
      r_state_valid <= 1'b0;
      r_vel_ena     <= 1'b0;
      r_pos_ena     <= 1'b0;
    end else begin
      r_err         <= 1'b0;
      r_state_valid <= 1'b0;
      if (w_abort) begin
        // Load is deferred one cycle so the unit enables drop first.
        r_pend    <= 1'b1;
        r_init    <= i_init_pos;
        r_vel_ena <= 1'b0;
        r_pos_ena <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            unique case (1'b1)
              w_load: begin
                r_pos    <= w_ld_pos;
                r_vel    <= '0;
                r_cnt    <= '0;
                r_done   <= 1'b0;
                r_trunc  <= 1'b0;
                r_loaded <= 1'b1;
                r_pend   <= 1'b0;
              end
              w_hs: begin
                r_act <= i_act;
                if (w_bad) begin
                  r_err <= 1'b1;
                end else begin
                  r_vel_ena <= 1'b1;
                  r_tmo     <= '0;
                end
              end
              default: ;
            endcase
          end
          VEL: begin
            if (i_vel_valid) begin
              r_vel_new <= w_vel_clamp;
              r_vel_ena <= 1'b0;
              r_pos_ena <= 1'b1;
              r_tmo     <= '0;
            end else if (w_tmo_hit) begin
              r_err     <= 1'b1;
              r_vel_ena <= 1'b0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          POS: begin
            if (i_pos_valid) begin
              r_pos_new <= i_pos;
              r_pos_ena <= 1'b0;
            end else if (w_tmo_hit) begin
              r_err     <= 1'b1;
              r_pos_ena <= 1'b0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          FIX: begin
            r_pos_new <= w_pos_clamp;
            // Inelastic left wall: stop the car when pinned there.
            if (w_pos_at_lo && w_vel_neg)
              r_vel_new <= '0;
          end
          PUB: begin
            r_pos         <= r_pos_new;
            r_vel         <= r_vel_new;
            r_cnt         <= w_cnt_nx;
            r_done        <= w_goal;
            r_trunc       <= (w_cnt_nx == CNT_MAX);
            r_state_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_act_ready   = w_ready;
  assign o_vel_ena     = r_vel_ena;
  assign o_vel_vel     = r_vel;
  assign o_vel_pos     = r_pos;
  assign o_vel_act     = r_act;
  assign o_pos_ena     = r_pos_ena;
  assign o_pos_pos     = r_pos;
  assign o_pos_vel     = r_vel_new;
  assign o_state_valid = r_state_valid;
  assign o_pos         = r_pos;
  assign o_vel         = r_vel;
  assign o_done        = r_done;
  assign o_trunc       = r_trunc;
  assign o_err         = r_err;
  assign o_step_cnt    = r_cnt;

endmodule

// File: tb/tb_mountaincar_step_ctrl.sv
// Bench for mountaincar_step_ctrl: vector table, corner
// sequences and a real-arithmetic reference model.
module tb_mountaincar_step_ctrl;

  localparam logic [31:0] VLIM   = 32'h3D8F5C29;
  localparam logic [31:0] VLIM_N = 32'hBD8F5C29;
  localparam logic [31:0] PMIN   = 32'hBF99999A;
  localparam logic [31:0] PMAX   = 32'h3F19999A;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ep_reset;
  logic [31:0] i_init_pos;
  logic        i_act_valid;
  logic        o_act_ready;
  logic [1:0]  i_act;
  logic        o_vel_ena;
  logic [31:0] o_vel_vel;
  logic [31:0] o_vel_pos;
  logic [1:0]  o_vel_act;
  logic        i_vel_valid;
  logic [31:0] i_vel;
  logic        o_pos_ena;
  logic [31:0] o_pos_pos;
  logic [31:0] o_pos_vel;
  logic        i_pos_valid;
  logic [31:0] i_pos;
  logic        o_state_valid;
  logic [31:0] o_pos;
  logic [31:0] o_vel;
  logic        o_done;
  logic        o_trunc;
  logic        o_err;
  logic [7:0]  o_step_cnt;

  always #5 i_clk = ~i_clk;

  mountaincar_step_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ep_reset(i_ep_reset), .i_init_pos(i_init_pos),
    .i_act_valid(i_act_valid), .o_act_ready(o_act_ready),
    .i_act(i_act), .o_vel_ena(o_vel_ena),
    .o_vel_vel(o_vel_vel), .o_vel_pos(o_vel_pos),
    .o_vel_act(o_vel_act), .i_vel_valid(i_vel_valid),
    .i_vel(i_vel), .o_pos_ena(o_pos_ena),
    .o_pos_pos(o_pos_pos), .o_pos_vel(o_pos_vel),
    .i_pos_valid(i_pos_valid), .i_pos(i_pos),
    .o_state_valid(o_state_valid), .o_pos(o_pos),
    .o_vel(o_vel), .o_done(o_done), .o_trunc(o_trunc),
    .o_err(o_err), .o_step_cnt(o_step_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pos;
  logic [31:0] m_vel;
  int          m_cnt;
  bit          m_done;
  bit          m_trunc;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:23] == 8'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] m_clamp(input logic [31:0] v,
      input logic [31:0] lo, input logic [31:0] hi);
    if (f2r(v) <= f2r(lo)) return lo;
    if (f2r(v) >= f2r(hi)) return hi;
    return v;
  endfunction

  function automatic logic [31:0] rnd_f(input int emin,
                                        input int emax);
    logic [31:0] r;
    r[31]    = 1'($urandom_range(1, 0));
    r[30:23] = 8'($urandom_range(emax, emin));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  task automatic chk_zero();
    chk("rst_ready", 32'(o_act_ready), 0);
    chk("rst_vel_ena", 32'(o_vel_ena), 0);
    chk("rst_pos_ena", 32'(o_pos_ena), 0);
    chk("rst_vel_ops", o_vel_vel | o_vel_pos | 32'(o_vel_act), 0);
    chk("rst_pos_ops", o_pos_pos | o_pos_vel, 0);
    chk("rst_sv", 32'(o_state_valid), 0);
    chk("rst_pos", o_pos, 0);
    chk("rst_vel", o_vel, 0);
    chk("rst_flags", {29'd0, o_done, o_trunc, o_err}, 0);
    chk("rst_cnt", 32'(o_step_cnt), 0);
  endtask

  task automatic ep_load(input logic [31:0] p);
    i_init_pos = p;
    i_ep_reset = 1'b1;
    @(negedge i_clk);
    i_ep_reset = 1'b0;
    m_pos = p; m_vel = '0; m_cnt = 0;
    m_done = 0; m_trunc = 0;
    chk("load_pos", o_pos, p);
    chk("load_vel", o_vel, 0);
    chk("load_cnt", 32'(o_step_cnt), 0);
    chk("load_flags", {o_done, o_trunc}, 0);
    chk("load_ready", 32'(o_act_ready), 1);
  endtask

  task automatic hs(input logic [1:0] a);
    i_act = a;
    i_act_valid = 1'b1;
    @(negedge i_clk);
    i_act_valid = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] a, input logic [31:0] v,
      input int vl, input logic [31:0] p, input int pl,
      output logic [31:0] pv);
    logic [31:0] ev;
    logic [31:0] ep;
    int n;
    chk("pre_ready", 32'(o_act_ready), 1);
    hs(a);
    chk("vel_ena_on", 32'(o_vel_ena), 1);
    repeat (vl) @(negedge i_clk);
    chk("vel_ena_hold", 32'(o_vel_ena), 1);
    chk("vel_ops", o_vel_vel ^ o_vel_pos, m_vel ^ m_pos);
    chk("vel_act", 32'(o_vel_act), 32'(a));
    i_vel = v; i_vel_valid = 1'b1;
    @(negedge i_clk);
    i_vel_valid = 1'b0; i_vel = $urandom;
    ev = m_clamp(v, VLIM_N, VLIM);
    pv = o_pos_vel;
    chk("vel_ena_off", 32'(o_vel_ena), 0);
    chk("pos_ena_on", 32'(o_pos_ena), 1);
    chk("pos_vel", o_pos_vel, ev);
    chk("pos_pos", o_pos_pos, m_pos);
    repeat (pl) @(negedge i_clk);
    i_pos = p; i_pos_valid = 1'b1;
    @(negedge i_clk);
    i_pos_valid = 1'b0; i_pos = $urandom;
    chk("pos_ena_off", 32'(o_pos_ena), 0);
    n = vl + pl + 2;
    while (!o_state_valid && n < vl + pl + 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("latency", 32'(n), 32'(4 + vl + pl));
    ep = m_clamp(p, PMIN, PMAX);
    if (f2r(ep) == f2r(PMIN) && f2r(ev) < 0.0) ev = '0;
    m_pos = ep; m_vel = ev; m_cnt++;
    m_done = (f2r(ep) >= 0.5) && (f2r(ev) >= 0.0);
    m_trunc = (m_cnt == 200);
    chk("st_pos", o_pos, m_pos);
    chk("st_vel", o_vel, m_vel);
    chk("st_cnt", 32'(o_step_cnt), 32'(m_cnt));
    chk("st_done", 32'(o_done), 32'(m_done));
    chk("st_trunc", 32'(o_trunc), 32'(m_trunc));
    @(negedge i_clk);
    chk("sv_pulse", 32'(o_state_valid), 0);
  endtask

  typedef struct {
    logic [31:0] init;
    logic [31:0] v;
    int          vl;
    logic [31:0] p;
    int          pl;
    logic [31:0] e_pv;
    logic [31:0] e_pos;
    logic [31:0] e_vel;
    logic        e_done;
  } vec_t;

  vec_t tv[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pv;
    logic [31:0] v;
    logic [31:0] p;
    logic [7:0]  cnt0;
    int n;

    tv[0] = '{32'hBF116098, 32'h39AD9C1E, 10, 32'hBF114AE5, 3,
              32'h39AD9C1E, 32'hBF114AE5, 32'h39AD9C1E, 1'b0};
    tv[1] = '{32'hBF000000, 32'h3DCCCCCD, 0, 32'hBF000000, 0,
              VLIM, 32'hBF000000, VLIM, 1'b0};
    tv[2] = '{32'hBF000000, 32'hBDCCCCCD, 2, 32'h3E800000, 1,
              VLIM_N, 32'h3E800000, VLIM_N, 1'b0};
    tv[3] = '{32'hBF800000, 32'hBA000000, 1, 32'hBFA00000, 2,
              32'hBA000000, PMIN, 32'h00000000, 1'b0};
    tv[4] = '{32'h3F000000, 32'h3A000000, 0, 32'h3F010000, 0,
              32'h3A000000, 32'h3F010000, 32'h3A000000, 1'b1};
    tv[5] = '{32'h3F000000, 32'h80000000, 3, 32'h3F000000, 0,
              32'h80000000, 32'h3F000000, 32'h80000000, 1'b1};
    tv[6] = '{32'h3F000000, 32'h3A000000, 0, 32'h3F400000, 4,
              32'h3A000000, PMAX, 32'h3A000000, 1'b1};
    tv[7] = '{PMIN, 32'h80000000, 1, PMIN, 1,
              32'h80000000, PMIN, 32'h80000000, 1'b0};
    tv[8] = '{32'h3F000000, 32'hBA000000, 0, 32'h3F000000, 0,
              32'hBA000000, 32'h3F000000, 32'hBA000000, 1'b0};

    i_rst_n = 1'b0; i_ep_reset = 1'b0; i_init_pos = '0;
    i_act_valid = 1'b0; i_act = '0;
    i_vel_valid = 1'b0; i_vel = '0;
    i_pos_valid = 1'b0; i_pos = '0;
    repeat (3) @(negedge i_clk);
    chk_zero();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("no_episode_ready", 32'(o_act_ready), 0);

    foreach (tv[i]) begin
      ep_load(tv[i].init);
      do_step(ACT1(), tv[i].v, tv[i].vl, tv[i].p, tv[i].pl, pv);
      chk("tv_pos_vel", pv, tv[i].e_pv);
      chk("tv_pos", o_pos, tv[i].e_pos);
      chk("tv_vel", o_vel, tv[i].e_vel);
      chk("tv_done", 32'(o_done), 32'(tv[i].e_done));
      if (tv[i].e_done) begin
        chk("done_ready", 32'(o_act_ready), 0);
        ep_load(32'hBF000000);
        chk("done_clr", 32'(o_done), 0);
      end
    end

    ep_load(32'hBF000000);
    for (int k = 0; k < 40; k++) begin
      if (m_done || m_trunc)
        ep_load(rnd_f(120, 126));
      v = rnd_f(112, 124);
      p = rnd_f(118, 127);
      if ($urandom_range(3, 0) == 0) p = 32'hBFA00000;
      do_step(2'($urandom_range(2, 0)), v, $urandom_range(5, 0),
              p, $urandom_range(5, 0), pv);
    end

    // bad action in IDLE
    ep_load(32'hBF000000);
    do_step(2'd2, 32'h3A000000, 0, 32'hBF000000, 0, pv);
    cnt0 = o_step_cnt;
    hs(2'd3);
    chk("bad_err", 32'(o_err), 1);
    chk("bad_no_vel", 32'(o_vel_ena), 0);
    chk("bad_ready", 32'(o_act_ready), 1);
    @(negedge i_clk);
    chk("bad_err_pulse", 32'(o_err), 0);
    chk("bad_cnt", 32'(o_step_cnt), 32'(cnt0));

    // stray unit valids in IDLE
    i_vel_valid = 1'b1; i_pos_valid = 1'b1;
    i_vel = 32'h3F800000; i_pos = 32'h3F800000;
    repeat (2) @(negedge i_clk);
    i_vel_valid = 1'b0; i_pos_valid = 1'b0;
    @(negedge i_clk);
    chk("stray_ena", {o_vel_ena, o_pos_ena, o_state_valid}, 0);
    chk("stray_pos", o_pos, m_pos);
    chk("stray_vel", o_vel, m_vel);

    // truncation at 200
    ep_load(32'hBF000000);
    for (int k = 0; k < 200; k++)
      do_step(2'd1, rnd_f(112, 118), 0, rnd_f(118, 125) | 32'h80000000,
              0, pv);
    chk("trunc_flag", 32'(o_trunc), 1);
    chk("trunc_cnt", 32'(o_step_cnt), 200);
    chk("trunc_ready", 32'(o_act_ready), 0);
    hs(2'd1);
    chk("trunc_no_accept", 32'(o_vel_ena), 0);

    // velocity watchdog
    ep_load(32'hBF000000);
    hs(2'd0);
    n = 0;
    while (!o_err && n < 80) begin
      @(negedge i_clk);
      n++;
    end
    chk("vel_tmo_cyc", 32'(n), 64);
    chk("vel_tmo_ena", {o_vel_ena, o_pos_ena}, 0);
    chk("vel_tmo_state", o_pos ^ 32'(o_step_cnt), m_pos);
    chk("vel_tmo_ready", 32'(o_act_ready), 1);
    @(negedge i_clk);
    chk("vel_tmo_pulse", 32'(o_err), 0);

    // position watchdog
    hs(2'd0);
    i_vel = 32'h3A000000; i_vel_valid = 1'b1;
    @(negedge i_clk);
    i_vel_valid = 1'b0;
    n = 0;
    while (!o_err && n < 80) begin
      @(negedge i_clk);
      n++;
    end
    chk("pos_tmo_cyc", 32'(n), 64);
    chk("pos_tmo_ena", {o_vel_ena, o_pos_ena}, 0);
    chk("pos_tmo_pos", o_pos, m_pos);

    // episode reset mid-step
    hs(2'd1);
    i_init_pos = 32'hBE800000; i_ep_reset = 1'b1;
    @(negedge i_clk);
    i_ep_reset = 1'b0;
    chk("abort_ena", {o_vel_ena, o_pos_ena}, 0);
    chk("abort_ready", 32'(o_act_ready), 0);
    @(negedge i_clk);
    chk("abort_pos", o_pos, 32'hBE800000);
    chk("abort_vel_cnt", o_vel | 32'(o_step_cnt), 0);
    chk("abort_ready2", 32'(o_act_ready), 1);
    m_pos = 32'hBE800000; m_vel = '0; m_cnt = 0;

    // episode reset wins over simultaneous action
    i_init_pos = 32'hBF200000; i_ep_reset = 1'b1;
    i_act = 2'd1; i_act_valid = 1'b1;
    @(negedge i_clk);
    i_ep_reset = 1'b0; i_act_valid = 1'b0;
    chk("race_no_vel", 32'(o_vel_ena), 0);
    chk("race_pos", o_pos, 32'hBF200000);
    m_pos = 32'hBF200000;

    // async reset while in POS
    hs(2'd2);
    i_vel = 32'h3A000000; i_vel_valid = 1'b1;
    @(negedge i_clk);
    i_vel_valid = 1'b0;
    chk("pre_rst_pos_ena", 32'(o_pos_ena), 1);
    #2 i_rst_n = 1'b0;
    #1 chk_zero();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", 32'(o_act_ready), 0);
    ep_load(32'hBF000000);
    do_step(2'd1, 32'h3A000000, 1, 32'hBEF00000, 1, pv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [1:0] ACT1();
    return 2'd1;
  endfunction

endmodule

// File: doc/mountaincar_step_ctrl.md
MOUNTAINCAR_STEP_CTRL -- requirements
Module: mountaincar_step_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- VEL_WL, 32, velocity width (IEEE-754 single).
- POS_WL, 32, position width (IEEE-754 single).
- ACT_WL, 2, action width.
- MAX_STEPS, 200, truncation limit.
- CNT_WL, 8, step counter width.
- TMO_CYC, 64, datapath watchdog limit.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_ep_reset, in, 1, start a new episode.
- i_init_pos, in, POS_WL, initial position.
- i_act_valid / o_act_ready, in/out, 1, action handshake.
- i_act, in, ACT_WL, action.
- o_vel_ena, out, 1, velocity unit enable.
- o_vel_vel / o_vel_pos / o_vel_act, out, VEL_WL/POS_WL/ACT_WL, velocity unit operands.
- i_vel_valid / i_vel, in, 1/VEL_WL, velocity unit result.
- o_pos_ena, out, 1, position unit enable.
- o_pos_pos / o_pos_vel, out, POS_WL/VEL_WL, position unit operands.
- i_pos_valid / i_pos, in, 1/POS_WL, position unit result.
- o_state_valid, out, 1, one-cycle pulse when the new state is published.
- o_pos / o_vel, out, POS_WL/VEL_WL, current state.
- o_done / o_trunc / o_err, out, 1, goal reached / step limit reached / error pulse.
- o_step_cnt, out, CNT_WL, steps taken this episode.

Function
REQ-003 The FSM SHALL use the states IDLE, VEL, POS, FIX and PUB.
REQ-004 IDLE: o_act_ready SHALL be 1 iff an episode is loaded and neither o_done nor o_trunc is set; a handshake SHALL latch i_act and enter VEL.
REQ-005 An action value of 3 SHALL be accepted, SHALL pulse o_err for one cycle, and SHALL leave the state unchanged in IDLE.
REQ-006 VEL: o_vel_ena SHALL be held at 1 with registered operands until the first cycle i_vel_valid=1; in that cycle i_vel SHALL be latched and o_vel_ena SHALL drop on the next edge.
REQ-007 Latched velocity SHALL be clamped to [-0.07, 0.07], with the limit magnitude 0x3D8F5C29 keeping the sign; the clamped value SHALL then go to POS.
REQ-008 POS: o_pos_ena SHALL follow the same hold-until-valid rule, with o_pos_vel set to the clamped velocity.
REQ-009 FIX: position SHALL be clamped to [-1.2 (0xBF99999A), 0.6 (0x3F19999A)].
REQ-010 FIX: if position equals -1.2 and velocity is negative, velocity SHALL become +0 (0x00000000).
REQ-011 Float compares SHALL use sign-magnitude rules, and -0 SHALL compare equal to +0.
REQ-012 PUB: o_pos/o_vel SHALL update, o_step_cnt SHALL increment, and o_state_valid SHALL pulse for one cycle.
REQ-013 PUB: o_done SHALL be set iff position >= 0.5 (0x3F000000) and velocity >= 0; o_trunc SHALL be set iff the new count equals MAX_STEPS.
REQ-014 PUB SHALL return to IDLE.
REQ-015 Minimum latency from handshake to o_state_valid is 4 cycles plus both unit latencies.
REQ-016 Watchdog: if VEL or POS lasts TMO_CYC cycles without valid, the block SHALL pulse o_err, drop both enables and return to IDLE with the state unchanged.
REQ-017 i_ep_reset in IDLE SHALL load o_pos=i_init_pos and o_vel=0, and SHALL clear o_step_cnt, o_done and o_trunc.
REQ-018 i_ep_reset outside IDLE SHALL abort the step, drop both enables, and perform the load in the next cycle.
REQ-019 If i_ep_reset and i_act_valid are both asserted in the same cycle, i_ep_reset SHALL win and the action SHALL NOT be accepted.
REQ-020 A stray i_vel_valid or i_pos_valid outside its own state SHALL be ignored.

Reset
REQ-021 i_rst_n low SHALL asynchronously force IDLE and "no episode loaded".
REQ-022 During reset, all outputs SHALL be 0, including o_pos, o_vel and o_step_cnt.
REQ-023 Reset release SHALL take effect on the next i_clk rising edge.

Structure
REQ-024 A shared package SHALL hold:
- the state enum;
- the float constants VEL_MAX, POS_MIN, POS_MAX and GOAL_POS;
- the action codes.
REQ-025 Float compare/clamp SHALL be one sub-module, mountaincar_fp_clamp (value, lo, hi -> clamped, at_lo, at_hi), instantiated for velocity and for position.

Verification
REQ-026 Episode reset with i_init_pos=0xBF116098, then act=1; the velocity stub returns 0x39AD9C1E after 10 cycles and the position stub returns 0xBF114AE5 -> o_vel=0x39AD9C1E, o_pos=0xBF114AE5, o_step_cnt=1, o_done=0, one o_state_valid pulse.
REQ-027 Velocity stub returns 0x3DCCCCCD (0.1) -> o_pos_vel=0x3D8F5C29; velocity stub returns 0xBDCCCCCD -> o_pos_vel=0xBD8F5C29.
REQ-028 Velocity 0xBA000000 and position stub returning 0xBFA00000 -> o_pos=0xBF99999A, o_vel=0x00000000.
REQ-029 Position stub returning 0x3F010000 with velocity 0x3A000000 -> o_done=1, o_act_ready=0; after i_ep_reset, o_done=0 and o_act_ready=1.
REQ-030 Run 200 steps -> o_trunc=1 at step 200; act=3 -> o_err pulse and o_step_cnt unchanged.
REQ-031 Velocity stub never asserts valid -> o_err pulses at cycle 64 of VEL; i_rst_n asserted low in POS -> all outputs 0 immediately.
